// File: rtl/paicore_handshake_engine_if.sv
// ---------------------------------------------------------------------------
// paicore_handshake_engine_if
//   Groups the stream-side and pad-side handshake signals of one PAICORE
//   channel.
//   master : the handshake engine. It drives s_tready, DAT_SEND, REQ_SEND,
//            ACK_RECV, m_tdata and m_tvalid.
//   slave  : the surroundings, meaning the stream producer and consumer and the
//            IOBUF pad layer. It drives s_tdata, s_tvalid, ACK_SEND, REQ_RECV,
//            DAT_RECV and m_tready.
// ---------------------------------------------------------------------------
interface paicore_handshake_engine_if;
  // TX stream (in) and TX pads (out)
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [31:0] DAT_SEND;
  logic        REQ_SEND;
  logic        ACK_SEND;
  // RX pads (in) and RX stream (out)
  logic        REQ_RECV;
  logic [31:0] DAT_RECV;
  logic        ACK_RECV;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;

  modport master (
    input  s_tdata, s_tvalid, ACK_SEND, REQ_RECV, DAT_RECV, m_tready,
    output s_tready, DAT_SEND, REQ_SEND, ACK_RECV, m_tdata, m_tvalid
  );

  modport slave (
    output s_tdata, s_tvalid, ACK_SEND, REQ_RECV, DAT_RECV, m_tready,
    input  s_tready, DAT_SEND, REQ_SEND, ACK_RECV, m_tdata, m_tvalid
  );
endinterface

// File: rtl/paicore_handshake_engine.sv
// ---------------------------------------------------------------------------
// paicore_handshake_engine
//   Per-channel 4-phase req/ack engine that sits behind the PAICORE pad IOBUF.
//   TX (oen=1): a word from the s_* stream is driven onto DAT_SEND, REQ_SEND
//               is raised, and the engine waits for ACK_SEND to rise and fall.
//   RX (oen=0): on REQ_RECV the engine captures DAT_RECV onto m_*, raises
//               ACK_RECV, and waits for REQ_RECV to fall.
//   The direction (oen) only changes while both FSMs are idle. Each change is
//   followed by TURN_CYCLES idle cycles.
// Ports
//   clk, rst    : clock and synchronous active-high reset
//   dir_tx      : requested direction (1=transmit, 0=receive)
//   oen         : pad direction handed to the IOBUF layer
//   err_clr     : clears timeout_err (a timeout in the same cycle wins)
//   timeout_err : sticky flag, a TX handshake timed out
//   busy        : an FSM is active or the turnaround counter is running
//   bus         : stream and pad handshake signals (master side)
// ---------------------------------------------------------------------------
module paicore_handshake_engine #(
  parameter int SYNC_STAGES  = 2,
  parameter int SETUP_CYCLES = 2,
  parameter int TURN_CYCLES  = 4,
  parameter int TIMEOUT      = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic dir_tx,
  output logic oen,
  input  logic err_clr,
  output logic timeout_err,
  output logic busy,
  paicore_handshake_engine_if.master bus
);

  typedef enum logic [1:0] {T_IDLE = 2'd0, T_SETUP = 2'd1, T_REQ = 2'd2, T_REL = 2'd3} tx_state_e;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_ACK = 1'b1} rx_state_e;

  localparam logic [15:0] SETUP_LOAD = 16'(SETUP_CYCLES - 1);
  localparam logic [15:0] TURN_LOAD  = 16'(TURN_CYCLES);
  localparam logic [15:0] TO_LAST    = 16'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam bit          TO_EN      = (TIMEOUT > 0);

  tx_state_e              tx_state_q;
  rx_state_e              rx_state_q;
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic [SYNC_STAGES-1:0] req_sync_q;
  logic [15:0]            cnt_q;
  logic [15:0]            turn_q;
  logic                   oen_q;
  logic [31:0]            dat_send_q;
  logic                   req_send_q;
  logic                   s_tready_q;
  logic                   ack_recv_q;
  logic [31:0]            m_tdata_q;
  logic                   m_tvalid_q;
  logic                   timeout_err_q;

  logic ack_s;
  logic req_s;
  logic turn_done_s;
  logic dir_change_s;
  logic tx_en_s;
  logic rx_en_s;
  logic to_hit_s;
  logic to_set_s;
  logic capture_s;

  // Only the last synchroniser stage reaches the FSMs.
  assign ack_s = ack_sync_q[SYNC_STAGES-1];
  assign req_s = req_sync_q[SYNC_STAGES-1];

  assign turn_done_s  = (turn_q == 16'd0);
  // A pending direction change takes priority over starting a new handshake.
  assign dir_change_s = (tx_state_q == T_IDLE) && (rx_state_q == R_IDLE) &&
                        turn_done_s && (dir_tx != oen_q);
  assign tx_en_s      = oen_q && turn_done_s && !dir_change_s;
  assign rx_en_s      = !oen_q && turn_done_s && !dir_change_s;
  assign to_hit_s     = TO_EN && (cnt_q == TO_LAST);
  assign to_set_s     = tx_en_s && to_hit_s &&
                        (((tx_state_q == T_REQ) && !ack_s) ||
                         ((tx_state_q == T_REL) && ack_s));
  // Capture only when the output register is empty or is being drained.
  assign capture_s    = rx_en_s && (rx_state_q == R_IDLE) && req_s &&
                        (!m_tvalid_q || bus.m_tready);

  assign oen          = oen_q;
  assign timeout_err  = timeout_err_q;
  assign bus.DAT_SEND = dat_send_q;
  assign bus.REQ_SEND = req_send_q;
  assign bus.s_tready = s_tready_q;
  assign bus.ACK_RECV = ack_recv_q;
  assign bus.m_tdata  = m_tdata_q;
  assign bus.m_tvalid = m_tvalid_q;
  // busy depends on state flops only, so it has no path from any input.
  assign busy = (tx_state_q != T_IDLE) || (rx_state_q != R_IDLE) || !turn_done_s;

  // Synchronisers, direction/turnaround control, and the TX and RX FSMs.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q    <= T_IDLE;
      rx_state_q    <= R_IDLE;
      ack_sync_q    <= '0;
      req_sync_q    <= '0;
      cnt_q         <= 16'd0;
      turn_q        <= 16'd0;
      oen_q         <= 1'b0;
      dat_send_q    <= 32'd0;
      req_send_q    <= 1'b0;
      s_tready_q    <= 1'b0;
      ack_recv_q    <= 1'b0;
      m_tdata_q     <= 32'd0;
      m_tvalid_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], bus.ACK_SEND};
      req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], bus.REQ_RECV};
      s_tready_q <= 1'b0;

      if (dir_change_s) begin
        oen_q  <= dir_tx;
        turn_q <= TURN_LOAD;
      end else if (!turn_done_s) begin
        turn_q <= turn_q - 16'd1;
      end

      if (to_set_s) begin
        timeout_err_q <= 1'b1;
      end else if (err_clr) begin
        timeout_err_q <= 1'b0;
      end

      if (tx_en_s) begin
        case (tx_state_q)
          T_IDLE: begin
            if (bus.s_tvalid) begin
              s_tready_q <= 1'b1;
              dat_send_q <= bus.s_tdata;
              cnt_q      <= SETUP_LOAD;
              tx_state_q <= T_SETUP;
            end
          end
          T_SETUP: begin
            if (cnt_q == 16'd0) begin
              req_send_q <= 1'b1;
              tx_state_q <= T_REQ;
            end else begin
              cnt_q <= cnt_q - 16'd1;
            end
          end
          T_REQ: begin
            // On a timeout the request is dropped and the word is lost.
            if (ack_s || to_hit_s) begin
              req_send_q <= 1'b0;
              cnt_q      <= 16'd0;
              tx_state_q <= T_REL;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
          T_REL: begin
            if (!ack_s || to_hit_s) begin
              cnt_q      <= 16'd0;
              tx_state_q <= T_IDLE;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
          default: tx_state_q <= T_IDLE;
        endcase
      end

      // A capture in the same cycle as m_tready keeps m_tvalid high.
      if (capture_s) begin
        m_tdata_q  <= bus.DAT_RECV;
        m_tvalid_q <= 1'b1;
      end else if (bus.m_tready) begin
        m_tvalid_q <= 1'b0;
      end

      if (rx_en_s) begin
        case (rx_state_q)
          R_IDLE: begin
            if (capture_s) begin
              ack_recv_q <= 1'b1;
              rx_state_q <= R_ACK;
            end
          end
          R_ACK: begin
            if (!req_s) begin
              ack_recv_q <= 1'b0;
              rx_state_q <= R_IDLE;
            end
          end
          default: rx_state_q <= R_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_paicore_handshake_engine.sv
// ---------------------------------------------------------------------------
// tb_paicore_handshake_engine
//   Directed bench for paicore_handshake_engine. TIMEOUT is set to 100 here.
//   Expected values are worked out by hand from the protocol timing.
// ---------------------------------------------------------------------------
module tb_paicore_handshake_engine;
  logic clk;
  logic rst;
  logic dir_tx;
  logic oen;
  logic err_clr;
  logic timeout_err;
  logic busy;
  int   total;
  int   bad;
  int   n;

  paicore_handshake_engine_if bus ();

  paicore_handshake_engine #(
    .SYNC_STAGES (2),
    .SETUP_CYCLES(2),
    .TURN_CYCLES (4),
    .TIMEOUT     (100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .dir_tx     (dir_tx),
    .oen        (oen),
    .err_clr    (err_clr),
    .timeout_err(timeout_err),
    .busy       (busy),
    .bus        (bus.master)
  );

  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic sel(input int w);
    case (w)
      0:       return bus.REQ_SEND;
      1:       return bus.s_tready;
      2:       return bus.ACK_RECV;
      3:       return oen;
      4:       return busy;
      default: return 1'b0;
    endcase
  endfunction

  localparam int W_REQ = 0, W_TRDY = 1, W_ACKR = 2, W_OEN = 3, W_BUSY = 4;

  // Bounded wait; an expired bound shows up as a failed comparison.
  task automatic wait_until(input int w, input logic v, input int maxc, input string tag);
    int k;
    k = 0;
    while (sel(w) !== v && k < maxc) begin
      tick();
      k++;
    end
    chk(tag, {31'd0, sel(w)}, {31'd0, v});
  endtask

  initial begin
    total = 0;
    bad = 0;
    clk = 1'b0;
    rst = 1'b1;
    dir_tx = 1'b0;
    err_clr = 1'b0;
    bus.s_tdata = 32'd0;
    bus.s_tvalid = 1'b0;
    bus.ACK_SEND = 1'b0;
    bus.REQ_RECV = 1'b0;
    bus.DAT_RECV = 32'd0;
    bus.m_tready = 1'b0;

    // 1 reset
    tick();
    tick();
    chk("rst_oen", {31'd0, oen}, 32'd0);
    chk("rst_req", {31'd0, bus.REQ_SEND}, 32'd0);
    chk("rst_ackr", {31'd0, bus.ACK_RECV}, 32'd0);
    chk("rst_mvalid", {31'd0, bus.m_tvalid}, 32'd0);
    chk("rst_trdy", {31'd0, bus.s_tready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    tick();

    // 2 TX of 0xDEADBEEF
    dir_tx = 1'b1;
    tick();
    chk("t2_oen", {31'd0, oen}, 32'd1);
    chk("t2_busy_turn", {31'd0, busy}, 32'd1);
    bus.s_tdata = 32'hDEADBEEF;
    bus.s_tvalid = 1'b1;
    n = 0;
    while (!bus.s_tready && n < 20) begin
      tick();
      n++;
    end
    chk("t2_accept_lat", n, 32'd5);
    chk("t2_dat", bus.DAT_SEND, 32'hDEADBEEF);
    bus.s_tvalid = 1'b0;
    bus.s_tdata = 32'h0;
    tick();
    chk("t2_trdy_pulse", {31'd0, bus.s_tready}, 32'd0);
    chk("t2_req_setup", {31'd0, bus.REQ_SEND}, 32'd0);
    tick();
    chk("t2_req_rise", {31'd0, bus.REQ_SEND}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_req_hold", {31'd0, bus.REQ_SEND}, 32'd1);
    end
    bus.ACK_SEND = 1'b1;
    tick();
    chk("t2_req_ack1", {31'd0, bus.REQ_SEND}, 32'd1);
    tick();
    chk("t2_req_ack2", {31'd0, bus.REQ_SEND}, 32'd1);
    tick();
    chk("t2_req_fall", {31'd0, bus.REQ_SEND}, 32'd0);
    chk("t2_dat_stable", bus.DAT_SEND, 32'hDEADBEEF);
    bus.ACK_SEND = 1'b0;
    wait_until(W_BUSY, 1'b0, 10, "t2_idle");
    chk("t2_dat_end", bus.DAT_SEND, 32'hDEADBEEF);

    // 3 RX with backpressure
    dir_tx = 1'b0;
    tick();
    chk("t3_oen", {31'd0, oen}, 32'd0);
    repeat (4) tick();
    chk("t3_turn_done", {31'd0, busy}, 32'd0);
    bus.DAT_RECV = 32'h12345678;
    bus.REQ_RECV = 1'b1;
    n = 0;
    while (!bus.ACK_RECV && n < 10) begin
      tick();
      n++;
    end
    chk("t3_ack_lat", n, 32'd3);
    chk("t3_mvalid1", {31'd0, bus.m_tvalid}, 32'd1);
    chk("t3_mdata1", bus.m_tdata, 32'h12345678);
    bus.REQ_RECV = 1'b0;
    wait_until(W_ACKR, 1'b0, 10, "t3_ack_drop1");
    bus.DAT_RECV = 32'hA5A5A5A5;
    bus.REQ_RECV = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t3_ack_withheld", {31'd0, bus.ACK_RECV}, 32'd0);
    end
    chk("t3_mdata_held", bus.m_tdata, 32'h12345678);
    bus.m_tready = 1'b1;
    tick();
    chk("t3_mdata2", bus.m_tdata, 32'hA5A5A5A5);
    chk("t3_mvalid2", {31'd0, bus.m_tvalid}, 32'd1);
    chk("t3_ack2", {31'd0, bus.ACK_RECV}, 32'd1);
    tick();
    chk("t3_mvalid_clr", {31'd0, bus.m_tvalid}, 32'd0);
    bus.m_tready = 1'b0;
    bus.REQ_RECV = 1'b0;
    wait_until(W_ACKR, 1'b0, 10, "t3_ack_drop2");

    // 4 timeout, with err_clr held while the timeout fires
    dir_tx = 1'b1;
    tick();
    repeat (4) tick();
    bus.s_tdata = 32'hCAFE0001;
    bus.s_tvalid = 1'b1;
    wait_until(W_TRDY, 1'b1, 10, "t4_accept");
    bus.s_tvalid = 1'b0;
    wait_until(W_REQ, 1'b1, 10, "t4_req_rise");
    err_clr = 1'b1;
    n = 0;
    while (bus.REQ_SEND && n < 200) begin
      tick();
      n++;
    end
    chk("t4_req_cycles", n, 32'd100);
    chk("t4_err_set_wins", {31'd0, timeout_err}, 32'd1);
    tick();
    err_clr = 1'b0;
    chk("t4_err_clr", {31'd0, timeout_err}, 32'd0);
    bus.s_tdata = 32'h00000042;
    bus.s_tvalid = 1'b1;
    tick();
    chk("t4_next_accept", {31'd0, bus.s_tready}, 32'd1);
    chk("t4_next_dat", bus.DAT_SEND, 32'h00000042);
    bus.s_tvalid = 1'b0;
    wait_until(W_REQ, 1'b1, 10, "t4_req2");
    bus.ACK_SEND = 1'b1;
    wait_until(W_REQ, 1'b0, 10, "t4_req2_fall");
    chk("t4_no_err", {31'd0, timeout_err}, 32'd0);
    bus.ACK_SEND = 1'b0;
    wait_until(W_BUSY, 1'b0, 10, "t4_idle");

    // 5 deferred turnaround
    bus.s_tdata = 32'h55AA55AA;
    bus.s_tvalid = 1'b1;
    wait_until(W_TRDY, 1'b1, 10, "t5_accept");
    bus.s_tvalid = 1'b0;
    wait_until(W_REQ, 1'b1, 10, "t5_req");
    dir_tx = 1'b0;
    repeat (3) tick();
    chk("t5_oen_hold_req", {31'd0, oen}, 32'd1);
    bus.ACK_SEND = 1'b1;
    wait_until(W_REQ, 1'b0, 10, "t5_req_fall");
    chk("t5_oen_hold_rel", {31'd0, oen}, 32'd1);
    bus.DAT_RECV = 32'h0BADF00D;
    bus.REQ_RECV = 1'b1;
    bus.ACK_SEND = 1'b0;
    wait_until(W_OEN, 1'b0, 10, "t5_oen_turn");
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_no_ack_turn", {31'd0, bus.ACK_RECV}, 32'd0);
    end
    tick();
    chk("t5_ack_after", {31'd0, bus.ACK_RECV}, 32'd1);
    chk("t5_mdata", bus.m_tdata, 32'h0BADF00D);
    bus.m_tready = 1'b1;
    bus.REQ_RECV = 1'b0;
    wait_until(W_ACKR, 1'b0, 10, "t5_ack_drop");
    tick();
    bus.m_tready = 1'b0;

    // 6 reset during T_REQ
    dir_tx = 1'b1;
    wait_until(W_OEN, 1'b1, 5, "t6_oen");
    wait_until(W_BUSY, 1'b0, 10, "t6_turn");
    bus.s_tdata = 32'h00000077;
    bus.s_tvalid = 1'b1;
    wait_until(W_TRDY, 1'b1, 10, "t6_accept");
    bus.s_tvalid = 1'b0;
    wait_until(W_REQ, 1'b1, 10, "t6_req");
    rst = 1'b1;
    tick();
    chk("t6_rst_req", {31'd0, bus.REQ_SEND}, 32'd0);
    chk("t6_rst_oen", {31'd0, oen}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    wait_until(W_OEN, 1'b1, 5, "t6_oen2");
    wait_until(W_BUSY, 1'b0, 10, "t6_turn2");
    bus.s_tdata = 32'h00000001;
    bus.s_tvalid = 1'b1;
    wait_until(W_TRDY, 1'b1, 10, "t6_accept2");
    chk("t6_dat", bus.DAT_SEND, 32'h00000001);
    bus.s_tvalid = 1'b0;
    wait_until(W_REQ, 1'b1, 10, "t6_req2");
    bus.ACK_SEND = 1'b1;
    wait_until(W_REQ, 1'b0, 10, "t6_req2_fall");
    bus.ACK_SEND = 1'b0;
    wait_until(W_BUSY, 1'b0, 10, "t6_idle");
    chk("t6_err", {31'd0, timeout_err}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
